// File: rtl/btn_conditioner.sv
// Push-button conditioning for the game block: synchronise, debounce, edge pulses
// and frame-paced auto-repeat (delayed auto-shift), one independent lane per button.

module btn_lane #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_n,
  input  logic frame_start,
  output logic level,
  output logic rise,
  output logic fall,
  output logic move
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int FW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] DELAY_LAST = FW'(REPEAT_DELAY - 1);
  localparam logic [FW-1:0] RATE_LAST  = FW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] db_cnt;
  state_t        state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], pin_n};
  end

  assign s = ~sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        level  <= ~level;
        rise   <= ~level;
        fall   <= level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Release wins over everything, including a repeat that is due this frame.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    move      = 1'b0;
    if (!level) begin
      state_nxt = IDLE;
      fcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          move      = 1'b1;
          fcnt_nxt  = '0;
          state_nxt = DELAY;
        end
        DELAY: if (frame_start) begin
          if (fcnt == DELAY_LAST) begin
            move      = 1'b1;
            fcnt_nxt  = '0;
            state_nxt = REPEAT;
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
        REPEAT: if (frame_start) begin
          if (fcnt == RATE_LAST) begin
            move     = 1'b1;
            fcnt_nxt = '0;
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end
endmodule

module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             frame_start,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_move
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_n      (btn_n[i]),
      .frame_start(frame_start),
      .level      (btn_level[i]),
      .rise       (btn_press[i]),
      .fall       (btn_release[i]),
      .move       (btn_move[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: glitch table, hand-timed auto-repeat sequences and a
// randomized run, all compared cycle-by-cycle against a behavioural model.

module tb_btn_conditioner;
  localparam int N = 2, DC = 8, RD = 3, RR = 2, FP = 20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] btn_n = '1;
  logic         frame_start = 1'b0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_move;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .frame_start(frame_start),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_move(btn_move)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, tcyc = 0;

  // Behavioural model: pin delay line, run-length debounce, frames-since-press cadence.
  bit m_h1[N], m_h2[N], m_lvl[N], m_prs[N], m_rls[N], m_held[N];
  int m_run[N], m_frames[N];

  int mv0[$], mv1[$];
  int pc[N];
  bit both_seen;
  int acc_hi, acc_prs, acc_rls, acc_mv;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d got %0d exp %0d", nm, tcyc, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int b = 0; b < N; b++) begin
      m_h1[b] = 1; m_h2[b] = 1; m_lvl[b] = 0; m_prs[b] = 0; m_rls[b] = 0;
      m_held[b] = 0; m_run[b] = 0; m_frames[b] = 0;
    end
  endtask

  function automatic bit mdl_move(input int b, input bit fs);
    int f;
    if (m_prs[b]) return 1'b1;
    if (m_held[b] && m_lvl[b] && fs) begin
      f = m_frames[b] + 1;
      return (f == RD) || (f > RD && (f - RD) % RR == 0);
    end
    return 1'b0;
  endfunction

  task automatic mdl_edge(input logic [N-1:0] pins, input bit fs);
    bit s;
    for (int b = 0; b < N; b++) begin
      s = !m_h2[b];
      if (!m_lvl[b]) begin
        m_held[b] = 0; m_frames[b] = 0;
      end else if (m_prs[b]) begin
        m_held[b] = 1; m_frames[b] = 0;
      end else if (m_held[b] && fs) begin
        m_frames[b]++;
      end
      m_prs[b] = 0; m_rls[b] = 0;
      if (s != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_lvl[b] = !m_lvl[b];
          m_run[b] = 0;
          m_prs[b] = m_lvl[b];
          m_rls[b] = !m_lvl[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_h2[b] = m_h1[b];
      m_h1[b] = pins[b];
    end
  endtask

  // One clock cycle: drive, compare against the model, record, advance.
  task automatic step(input logic [N-1:0] pins);
    logic [N-1:0] el, ep, er, em;
    bit fs;
    fs = (tcyc % FP == 0);
    btn_n = pins;
    frame_start = fs;
    #1;
    for (int b = 0; b < N; b++) begin
      el[b] = m_lvl[b]; ep[b] = m_prs[b]; er[b] = m_rls[b]; em[b] = mdl_move(b, fs);
    end
    chk("btn_level", int'(btn_level), int'(el));
    chk("btn_press", int'(btn_press), int'(ep));
    chk("btn_release", int'(btn_release), int'(er));
    chk("btn_move", int'(btn_move), int'(em));
    if (btn_move[0]) mv0.push_back(tcyc);
    if (btn_move[1]) mv1.push_back(tcyc);
    for (int b = 0; b < N; b++) if (btn_press[b]) pc[b] = tcyc;
    if (btn_move == 2'b11) both_seen = 1;
    acc_hi += int'(btn_level[0]); acc_prs += int'(btn_press[0]);
    acc_rls += int'(btn_release[0]); acc_mv += int'(btn_move[0]);
    @(posedge clk); #1;
    mdl_edge(pins, fs);
    tcyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b11);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FP && (tcyc % FP) != ph; i++) step(2'b11);
  endtask

  task automatic clear_rec();
    mv0.delete(); mv1.delete(); pc[0] = -1; pc[1] = -1; both_seen = 0;
  endtask

  task automatic press_latency(input string nm);
    int n;
    n = 0;
    while (n < 20 && !btn_level[0]) begin
      step(2'b10);
      n++;
    end
    chk(nm, n, DC + 2);
    chk({nm, "_press"}, int'(btn_press[0]), 1);
    chk({nm, "_move"}, int'(btn_move[0]), 1);
  endtask

  typedef struct {
    int low1, gap, low2;
    int e_hi, e_prs, e_rls, e_mv;
  } glitch_t;

  initial begin
    glitch_t tbl[9];
    int expa[5], expb[2], expc0[8], expc1[2];
    int start;
    logic [N-1:0] pins;
    int hold[N];

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{5, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{7, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{8, 0, 0, 8, 1, 1, 1};
    tbl[4] = '{9, 0, 0, 9, 1, 1, 1};
    tbl[5] = '{12, 0, 0, 12, 1, 1, 1};
    tbl[6] = '{5, 1, 5, 0, 0, 0, 0};
    tbl[7] = '{7, 1, 7, 0, 0, 0, 0};
    tbl[8] = '{6, 1, 9, 9, 1, 1, 1};
    expa  = '{0, 55, 95, 135, 175};
    expb  = '{0, 60};
    expc0 = '{0, 55, 95, 135, 175, 215, 255, 295};
    expc1 = '{0, 60};

    // Reset held with button 0 down: everything quiet, then a fresh press.
    btn_n = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(btn_press), 0);
    chk("rst_release", int'(btn_release), 0);
    chk("rst_move", int'(btn_move), 0);
    mdl_reset();
    reset_n = 1'b1;
    clear_rec();
    press_latency("rst_latency");
    step(2'b10);
    chk("press_one_cycle", int'(btn_press[0]), 0);
    repeat (5) step(2'b10);

    // Asynchronous reset mid-hold clears outputs before any edge.
    reset_n = 1'b0;
    #1;
    chk("async_level", int'(btn_level), 0);
    chk("async_move", int'(btn_move), 0);
    @(posedge clk); #1;
    mdl_reset();
    reset_n = 1'b1;
    press_latency("rehold_latency");
    idle(30);

    // Glitch / boundary table on button 0.
    for (int i = 0; i < 9; i++) begin
      acc_hi = 0; acc_prs = 0; acc_rls = 0; acc_mv = 0;
      repeat (tbl[i].low1) step(2'b10);
      repeat (tbl[i].gap) step(2'b11);
      repeat (tbl[i].low2) step(2'b10);
      idle(30);
      chk($sformatf("glitch%0d_hi", i), acc_hi, tbl[i].e_hi);
      chk($sformatf("glitch%0d_press", i), acc_prs, tbl[i].e_prs);
      chk($sformatf("glitch%0d_release", i), acc_rls, tbl[i].e_rls);
      chk($sformatf("glitch%0d_move", i), acc_mv, tbl[i].e_mv);
    end

    // Auto-repeat cadence, ending with a release that lands on a due repeat frame.
    wait_phase(15);
    clear_rec();
    start = tcyc;
    repeat (215) step(2'b10);
    idle(30);
    chk("rep_press_lat", pc[0] - start, DC + 2);
    chk("rep_nmoves", mv0.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rep_move%0d", k), (k < mv0.size()) ? mv0[k] - pc[0] : -1, expa[k]);

    // After release-priority the next press moves immediately.
    clear_rec();
    start = tcyc;
    repeat (20) step(2'b10);
    idle(30);
    chk("repress_lat", pc[0] - start, DC + 2);
    chk("repress_move", (mv0.size() > 0) ? mv0[0] - pc[0] : -1, 0);

    // Press coincident with frame_start: that strobe is not counted.
    wait_phase(10);
    clear_rec();
    start = tcyc;
    repeat (80) step(2'b10);
    idle(30);
    chk("coinc_nmoves", mv0.size(), 2);
    for (int k = 0; k < 2; k++)
      chk($sformatf("coinc_move%0d", k), (k < mv0.size()) ? mv0[k] - pc[0] : -1, expb[k]);

    // Independence: button 1 pressed while button 0 is repeating.
    wait_phase(15);
    clear_rec();
    for (int i = 0; i < 300; i++) begin
      pins = 2'b10;
      if (i >= 95 && i < 195) pins[1] = 1'b0;
      step(pins);
    end
    idle(30);
    chk("indep_offset", pc[1] - pc[0], 95);
    chk("indep_n0", mv0.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("indep0_move%0d", k), (k < mv0.size()) ? mv0[k] - pc[0] : -1, expc0[k]);
    chk("indep_n1", mv1.size(), 2);
    for (int k = 0; k < 2; k++)
      chk($sformatf("indep1_move%0d", k), (k < mv1.size()) ? mv1[k] - pc[1] : -1, expc1[k]);
    chk("indep_both", int'(both_seen), 1);

    // Randomized holds on both buttons.
    pins = 2'b11;
    hold[0] = 1; hold[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          pins[b] = ~pins[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 150))
                                                : int'($urandom_range(1, 40));
        end
      end
      step(pins);
    end
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw active-low push-button pins (left/right) before they reach the Tetris game logic. Currently those pins go straight in.
- Per button: 2-flop synchronisation, counter-based debounce, a single-cycle press pulse, and a frame-paced auto-repeat "move" pulse (delayed auto-shift).
- Sits between the top-level button pins and the game block. Shares the 27 MHz clock and the ~60 Hz frame_start strobe with the LCD path.

Parameters:
- N_BTN, 2, number of independent buttons.
- DEBOUNCE_CYCLES, 270000, consecutive clk cycles a changed synced level must hold before acceptance (10 ms at 27 MHz); must be ≥2.
- REPEAT_DELAY, 16, frame_start strobes from press to first auto-repeat move; must be ≥1.
- REPEAT_RATE, 4, frame_start strobes between subsequent auto-repeat moves; must be ≥1.

Ports:
- clk, input, 1, system clock (27 MHz).
- reset_n, input, 1, asynchronous active-low reset.
- btn_n, input, N_BTN, raw button pins; active low; asynchronous to clk.
- frame_start, input, 1, single-cycle frame strobe (~60 Hz).
- btn_level, output, N_BTN, debounced level; 1 = held.
- btn_press, output, N_BTN, 1-cycle pulse on each debounced press edge.
- btn_release, output, N_BTN, 1-cycle pulse on each debounced release edge.
- btn_move, output, N_BTN, 1-cycle pulse on the initial press and on each auto-repeat.

Behaviour:
- Reset: all outputs 0 immediately (async). Synchroniser flops reset to 1 (released). Debounce counters are 0. Repeat FSMs are in IDLE with their frame counters at 0. Reset mid-hold: after release of reset, a still-held button is treated as a new press once it passes debounce.
- Each button is fully independent. There is no cross-button arbitration; simultaneous moves on both buttons are legal.
- Synchroniser: two flops on btn_n[i]. The synced level is s[i] = ~sync2[i] (1 = pressed).
- Debounce, per button:
  - The counter width is $clog2(DEBOUNCE_CYCLES).
  - If s == btn_level, the counter clears to 0.
  - Otherwise the counter increments each cycle. On the cycle the count equals DEBOUNCE_CYCLES-1, btn_level toggles on the next edge and the counter clears.
  - Any glitch back to s == btn_level before acceptance restarts the count from 0.
  - Latency: a clean pin edge is reflected in btn_level exactly DEBOUNCE_CYCLES+2 clk edges later.
- btn_press = btn_level rising edge; btn_release = btn_level falling edge. Both are registered, asserted for exactly the first cycle btn_level holds its new value, and never asserted together for one button.
- Repeat FSM per button, with states IDLE, DELAY, REPEAT and a frame counter of width $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1):
  - IDLE: on btn_press, assert btn_move in the same cycle as btn_press, clear the counter, and go to DELAY.
  - DELAY: each frame_start increments the counter. On the frame_start that brings the count to REPEAT_DELAY, assert btn_move in that cycle, clear the counter, and go to REPEAT.
  - REPEAT: each frame_start increments the counter. On the frame_start that brings the count to REPEAT_RATE, assert btn_move and clear the counter.
  - Any state: if btn_level is 0 (released), go to IDLE and clear the counter, with no btn_move. Release has priority over a coincident frame_start.
- A frame_start coincident with btn_press is not counted; DELAY starts at 0.
- btn_move is never asserted on two consecutive cycles for one button.
- The counters never wrap. A hold of arbitrary length keeps repeating at REPEAT_RATE indefinitely.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=3, REPEAT_RATE=2, frame_start every 20 clk):
- Reset behaviour: hold reset_n=0 with btn_n=0 → all outputs 0. Release reset → btn_level[0]=1 exactly 10 edges later, with btn_press[0] and btn_move[0] each high 1 cycle.
- Glitch rejection: pulse btn_n[0] low for 5 cycles, then high → no btn_level/btn_press/btn_move activity. A 9-cycle low pulse → btn_level goes high 10 edges after the fall, then falls 10 edges after the rise, with btn_release pulsing once.
- Auto-repeat timing: hold btn 0 for 200 cycles → a btn_move at press, then on the 3rd frame_start after press, then on every 2nd frame_start after that. Count the exact pulses against the expected list.
- Release priority: release btn 0 so that btn_level falls in the same cycle as a due repeat frame_start → no btn_move. FSM returns to IDLE; the next press gives an immediate btn_move.
- Independence: press btn 1 while btn 0 is in REPEAT → btn 0 cadence is unchanged. Btn 1 gets its own immediate move, and coincident btn_move[0] and btn_move[1] pulses are both observed.
- Coincident strobe: align btn_press with frame_start → the first repeat lands 3 further frame_starts later, not 2.
